propagation_controller: RTL
===========================

# propagation_controller

Sequential driver for the combinational three-colour `reasoning_core`; it owns the core's input side and consumes its output side. On `start` it latches a colour-mask snapshot, adjacency matrix and per-node question-bit costs. It then iterates propagation rounds through the core until a fixpoint, a conflict or a round limit is reached. Across rounds it accumulates the μ-spec v2.0 terms (question bits, Q16 information gain) and the legacy activity count, so the host reads totals instead of per-round values.

## Interface
- `NODES`, 9, vertex count; must equal the attached core's `NODES`.
- `MAX_ROUNDS`, 16, maximum committed rounds per run; ≥1.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `init_masks`  in  3*NODES  initial per-node candidate masks; node i occupies bits [3i+2:3i].
- `init_adjacency`  in  NODES*NODES  adjacency; bit i*NODES+j set means j constrains i.
- `init_question_bits`  in  32*NODES  per-node question-bit cost.
- `core_node_masks`  out  3*NODES  registered working masks, to the core.
- `core_adjacency`  out  NODES*NODES  latched adjacency, to the core.
- `core_node_question_bits`  out  32*NODES  latched costs, to the core.
- `core_forced_masks`  in  3*NODES  core candidate masks.
- `core_force_valid`  in  NODES  core forced flags (status only).
- `core_activity_count`  in  $clog2(4*NODES+1)  core per-round activity.
- `core_question_bits`  in  32  core per-round question bits.
- `core_information_gain_q16`  in  32  core per-round gain.
- `busy`  out  1  high in PROP.
- `done`  out  1  one-cycle pulse on completion.
- `status`  out  2  0 = none, 1 = FIXPOINT, 2 = CONFLICT, 3 = ROUND_LIMIT.
- `rounds`  out  $clog2(MAX_ROUNDS+1)  committed rounds.
- `question_total`  out  32  saturating sum of core_question_bits.
- `info_total_q16`  out  32  saturating sum of gains.
- `activity_total`  out  32  saturating sum of activity.

## Operation
- States: IDLE, PROP, DONE.
- IDLE: if `start` is high, the controller does all of the following and moves to PROP:
  - latch `init_*` into the core-driving registers;
  - clear `rounds` and all totals;
  - set `status` = 0.
- `start` in PROP or DONE is ignored.
- PROP evaluates one round per cycle on the combinational core outputs, which reflect the current working masks. Checks run in priority order:
  1. CONFLICT: if any 3-bit field of `core_forced_masks` is 000, set `status` = 2 and go to DONE. No commit, no accumulation.
  2. FIXPOINT: else if `core_forced_masks` == `core_node_masks`, set `status` = 1 and go to DONE. No commit.
  3. Commit: otherwise:
     - working masks ← `core_forced_masks` (all nodes, including narrowings that are not forced);
     - add the three core metrics to their totals;
     - `rounds` ← `rounds`+1;
     - if the new `rounds` == `MAX_ROUNDS`, set `status` = 3 and go to DONE.
- DONE: `done` = 1 for exactly this cycle, then go to IDLE.
- Results (working masks, totals, `rounds`, `status`) hold until the next accepted `start` or `rst`.
- Arithmetic: all totals are 32-bit unsigned and saturate at 0xFFFF_FFFF. `core_activity_count` is zero-extended before adding.
- `rst` in any state, including mid-run:
  - state ← IDLE;
  - all registered outputs ← 0, including core-driving registers;
  - the run is abandoned with no `done`.

## Timing
- `start` sampled at edge 0 → PROP from cycle 1.
- A run with k commits ending in FIXPOINT or CONFLICT reaches PROP's final check in cycle k+1; `done` is high in cycle k+2.
- ROUND_LIMIT: `done` is high in cycle `MAX_ROUNDS`+1.
- The next `start` is accepted the cycle after `done`.
- Reset values: `busy` = 0, `done` = 0, `status` = 0, `rounds` = 0, all totals = 0, all `core_*` outputs = 0.
- Totals, `rounds` and working masks update on the commit edge. They are stable and final when `done` is high.

## Test plan
- Triangle 0–1–2, masks 0:001, 1:011, 2:111, questions {5, 7, 11}:
  - → `status` = 1, `rounds` = 2;
  - → final masks 001/010/100;
  - → `question_total` = 18, `info_total_q16` = 131072, `activity_total` = 4;
  - → `done` in cycle 4.
- Triangle, all masks 001 → `status` = 2, `rounds` = 0, totals 0, `done` in cycle 2.
- First test's stimulus with `MAX_ROUNDS` = 1 → `status` = 3, `rounds` = 1, masks 001/010/110, `done` in cycle 2.
- Saturation: a bench model drives `core_question_bits` = 0x8000_0000 for 3 rounds → `question_total` = 0xFFFF_FFFF.
- `start` pulsed every cycle during a run:
  - → only one run occurs;
  - → a second run starts the cycle after `done`.
- `rst` asserted in cycle 2 of a run:
  - → next cycle IDLE, all outputs 0, no `done`;
  - → a new `start` completes normally.

Source files
------------

// File: rtl/propagation_controller.sv
// -----------------------------------------------------------------------------
// propagation_controller
//
// Sequential driver for the combinational three-colour reasoning_core. A run
// request latches a snapshot of the problem (candidate masks, adjacency and
// per-node question-bit costs) into registers that drive the core. The
// controller then feeds the core's narrowed masks back into those registers
// once per cycle. It stops when the core reaches a fixpoint, produces an empty
// candidate set (conflict), or the round limit is hit. The per-round core
// metrics are summed into saturating 32-bit totals for the host.
//
// Parameters
//   NODES       vertex count; must match the attached core
//   MAX_ROUNDS  maximum committed rounds per run (>= 1)
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   start                      run request, honoured only when idle
//   init_masks                 initial 3-bit candidate mask per node
//   init_adjacency             bit i*NODES+j set: node j constrains node i
//   init_question_bits         32-bit question cost per node
//   core_node_masks            working masks driven to the core
//   core_adjacency             latched adjacency driven to the core
//   core_node_question_bits    latched costs driven to the core
//   core_forced_masks          core's narrowed masks for the current round
//   core_force_valid           core's forced flags (informational only)
//   core_activity_count        core's per-round activity
//   core_question_bits         core's per-round question bits
//   core_information_gain_q16  core's per-round Q16 information gain
//   busy                       high while rounds are being evaluated
//   done                       one-cycle completion pulse
//   status                     0 none, 1 fixpoint, 2 conflict, 3 round limit
//   rounds                     committed rounds in the current/last run
//   question_total             saturating sum of core_question_bits
//   info_total_q16             saturating sum of core_information_gain_q16
//   activity_total             saturating sum of core_activity_count
// -----------------------------------------------------------------------------
module propagation_controller #(
  parameter int NODES      = 9,
  parameter int MAX_ROUNDS = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [3*NODES-1:0]                 init_masks,
  input  logic [NODES*NODES-1:0]             init_adjacency,
  input  logic [32*NODES-1:0]                init_question_bits,
  output logic [3*NODES-1:0]                 core_node_masks,
  output logic [NODES*NODES-1:0]             core_adjacency,
  output logic [32*NODES-1:0]                core_node_question_bits,
  input  logic [3*NODES-1:0]                 core_forced_masks,
  input  logic [NODES-1:0]                   core_force_valid,
  input  logic [$clog2(4*NODES+1)-1:0]       core_activity_count,
  input  logic [31:0]                        core_question_bits,
  input  logic [31:0]                        core_information_gain_q16,
  output logic                               busy,
  output logic                               done,
  output logic [1:0]                         status,
  output logic [$clog2(MAX_ROUNDS+1)-1:0]    rounds,
  output logic [31:0]                        question_total,
  output logic [31:0]                        info_total_q16,
  output logic [31:0]                        activity_total
);

  localparam int RW = $clog2(MAX_ROUNDS + 1);
  localparam int AW = $clog2(4 * NODES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE        = 2'd0,
    ST_FIXPOINT    = 2'd1,
    ST_CONFLICT    = 2'd2,
    ST_ROUND_LIMIT = 2'd3
  } status_t;

  // Totals must not wrap: a wrapped total would silently under-report cost.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  state_t                    r_state;
  status_t                   r_status;
  logic                      r_busy;
  logic                      r_done;
  logic [RW-1:0]             r_rounds;
  logic [3*NODES-1:0]        r_masks;
  logic [NODES*NODES-1:0]    r_adjacency;
  logic [32*NODES-1:0]       r_question_bits;
  logic [31:0]               r_question_total;
  logic [31:0]               r_info_total;
  logic [31:0]               r_activity_total;

  logic                      w_conflict;
  logic                      w_fixpoint;
  logic [RW-1:0]             w_rounds_next;
  logic [31:0]               w_activity_ext;

  // Forced flags are derivable from the masks themselves; the controller only
  // needs the masks, so this input is deliberately left unconsumed.
  logic                      w_unused_force_valid;
  assign w_unused_force_valid = ^core_force_valid;

  // A node whose candidate set has been emptied makes the problem unsatisfiable.
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NODES; i++) begin
      if (core_forced_masks[3*i +: 3] == 3'b000) w_conflict = 1'b1;
    end
  end

  // Fixpoint compares every node's mask, not just forced ones: a narrowing
  // without a force is still progress and must be committed.
  assign w_fixpoint     = (core_forced_masks == r_masks);
  assign w_rounds_next  = r_rounds + RW'(1);
  assign w_activity_ext = {{(32-AW){1'b0}}, core_activity_count};

  // NOTE: every register, including the wide core-driving ones, is cleared on
  // reset so an abandoned run never leaks stale state into the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_status         <= ST_NONE;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_rounds         <= '0;
      r_masks          <= '0;
      r_adjacency      <= '0;
      r_question_bits  <= '0;
      r_question_total <= '0;
      r_info_total     <= '0;
      r_activity_total <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register in this block sees
      // the pre-edge values, independent of statement order.
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_masks          <= init_masks;
            r_adjacency      <= init_adjacency;
            r_question_bits  <= init_question_bits;
            r_rounds         <= '0;
            r_question_total <= '0;
            r_info_total     <= '0;
            r_activity_total <= '0;
            r_status         <= ST_NONE;
            r_busy           <= 1'b1;
            r_state          <= S_PROP;
          end
        end

        S_PROP: begin
          if (w_conflict) begin
            r_status <= ST_CONFLICT;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (w_fixpoint) begin
            r_status <= ST_FIXPOINT;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_masks          <= core_forced_masks;
            r_question_total <= sat_add(r_question_total, core_question_bits);
            r_info_total     <= sat_add(r_info_total, core_information_gain_q16);
            r_activity_total <= sat_add(r_activity_total, w_activity_ext);
            r_rounds         <= w_rounds_next;
            // The limit is checked on the round just committed, so the last
            // allowed round is still accumulated.
            if (w_rounds_next == RW'(MAX_ROUNDS)) begin
              r_status <= ST_ROUND_LIMIT;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign core_node_masks         = r_masks;
  assign core_adjacency          = r_adjacency;
  assign core_node_question_bits = r_question_bits;
  assign busy                    = r_busy;
  assign done                    = r_done;
  assign status                  = r_status;
  assign rounds                  = r_rounds;
  assign question_total          = r_question_total;
  assign info_total_q16          = r_info_total;
  assign activity_total          = r_activity_total;

endmodule
